// File: rtl/addsub_pkg.sv
// Shared types for the carry-segmented pipelined adder/subtractor.
// Holds the operation encoding, the flag bundle and the flag derivation helper.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic cout;
    logic borrow;
    logic ovf;
    logic zero;
    logic neg;
  } addsub_flags_t;

  // b_msb is the MSB of the operand actually fed to the adder (B for ADD, ~B for SUB).
  function automatic addsub_flags_t derive_flags(
    input op_e  op,
    input logic carry,
    input logic a_msb,
    input logic b_msb,
    input logic r_msb,
    input logic zero_all
  );
    addsub_flags_t f;
    f.cout   = carry;
    f.borrow = (op == OP_SUB) && !carry;
    f.ovf    = (a_msb == b_msb) && (r_msb != a_msb);
    f.zero   = zero_all;
    f.neg    = r_msb;
    return f;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG_W-bit slice of the pipelined adder: combinational add of the slice plus
// the registered sum, carry and running zero indication, all frozen while en is low.
module addsub_seg #(
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  input  logic             zin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             zout
);

  logic [SEG_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      zout <= 1'b0;
    end else if (en) begin
      sum  <= total[SEG_W-1:0];
      cout <= total[SEG_W];
      zout <= zin && (total[SEG_W-1:0] == '0);
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined integer adder/subtractor, one carry segment per stage, with valid/ready
// flow control and a full flag set derived from the last stage.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG_W = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a multiple of STAGES");
  end

  logic                           stall;
  logic                           adv;
  logic                           accept;
  logic [WIDTH-1:0]               bx_in;
  logic [STAGES-1:0]              vld_q;
  op_e                            op_q [STAGES];
  logic [STAGES-1:0][WIDTH-1:0]   a_q;
  logic [STAGES-1:0][WIDTH-1:0]   bx_q;
  logic [STAGES-1:0][WIDTH-1:0]   skew_q;
  logic [STAGES-1:0][WIDTH-1:0]   res_cur;
  logic [STAGES-1:0][SEG_W-1:0]   seg_sum;
  logic [STAGES-1:0]              carry_q;
  logic [STAGES-1:0]              zero_q;
  addsub_flags_t                  flags;

  assign out_valid = vld_q[STAGES-1];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign adv       = !stall;
  assign accept    = in_valid && in_ready;

  // Subtraction runs as A + ~B + 1; the +1 enters as the stage-0 carry-in.
  assign bx_in = (op == OP_SUB) ? ~reg2 : reg2;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [SEG_W-1:0] a_seg;
    logic [SEG_W-1:0] b_seg;
    logic             cin;
    logic             zin;

    if (k == 0) begin : g_first
      assign a_seg = reg1[SEG_W-1:0];
      assign b_seg = bx_in[SEG_W-1:0];
      assign cin   = (op == OP_SUB);
      assign zin   = 1'b1;
    end else begin : g_rest
      assign a_seg = a_q[k-1][k*SEG_W +: SEG_W];
      assign b_seg = bx_q[k-1][k*SEG_W +: SEG_W];
      assign cin   = carry_q[k-1];
      assign zin   = zero_q[k-1];
    end

    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (adv),
      .a    (a_seg),
      .b    (b_seg),
      .cin  (cin),
      .zin  (zin),
      .sum  (seg_sum[k]),
      .cout (carry_q[k]),
      .zout (zero_q[k])
    );
  end

  // Stage k's visible result: finished lower segments from the skew register
  // plus the segment it just produced. skew_q[0] stays zero.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res_cur[k]                   = skew_q[k];
      res_cur[k][k*SEG_W +: SEG_W] = seg_sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a_q    <= '0;
      bx_q   <= '0;
      skew_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        op_q[k] <= OP_ADD;
      end
    end else if (adv) begin
      vld_q[0] <= accept;
      op_q[0]  <= op;
      a_q[0]   <= reg1;
      bx_q[0]  <= bx_in;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k]  <= vld_q[k-1];
        op_q[k]   <= op_q[k-1];
        a_q[k]    <= a_q[k-1];
        bx_q[k]   <= bx_q[k-1];
        skew_q[k] <= res_cur[k-1];
      end
    end
  end

  assign result = res_cur[STAGES-1];

  assign flags = derive_flags(op_q[STAGES-1], carry_q[STAGES-1],
                              a_q[STAGES-1][WIDTH-1], bx_q[STAGES-1][WIDTH-1],
                              res_cur[STAGES-1][WIDTH-1], zero_q[STAGES-1]);

  assign cout   = flags.cout;
  assign borrow = flags.borrow;
  assign ovf    = flags.ovf;
  assign zero   = flags.zero;
  assign neg    = flags.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: arithmetic reference model with an output
// scoreboard, plus directed vectors with hand-computed results, stalls and mid-flight reset.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         b;
    logic         o;
    logic         z;
    logic         n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  op_e          op = OP_ADD;
  logic [W-1:0] reg1 = '0;
  logic [W-1:0] reg2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout, borrow, ovf, zero, neg;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  exp_t exp_q[$];
  logic stalled_prev = 1'b0;
  exp_t held;

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .reg1     (reg1),
    .reg2     (reg2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .borrow   (borrow),
    .ovf      (ovf),
    .zero     (zero),
    .neg      (neg)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [W-1:0] r, logic c, logic b, logic o, logic z, logic n);
    exp_t e;
    e.res = r; e.c = c; e.b = b; e.o = o; e.z = z; e.n = n;
    return e;
  endfunction

  // Reference: plain unsigned/signed arithmetic on wide integers.
  function automatic exp_t model(op_e o, logic [W-1:0] a, logic [W-1:0] b);
    exp_t        e;
    longint      sa, sb, sr, smax, smin;
    logic [W:0]  wide;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (o == OP_SUB) begin
      e.res = a - b;
      e.c   = (a >= b);
      e.b   = (a < b);
      sr    = sa - sb;
    end else begin
      wide  = {1'b0, a} + {1'b0, b};
      e.res = wide[W-1:0];
      e.c   = wide[W];
      e.b   = 1'b0;
      sr    = sa + sb;
    end
    e.o = (sr > smax) || (sr < smin);
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t dut_out();
    return mk(result, cout, borrow, ovf, zero, neg);
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    stalled_prev = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(op, reg1, reg2));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      stalled_prev = out_valid && !out_ready;
      held = dut_out();
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
      else chk("scoreboard", dut_out(), exp_q[0]);
      if (stalled_prev) chk("hold_while_stalled", dut_out(), held);
    end
  end

  task automatic run_one(string name, op_e o, logic [W-1:0] a, logic [W-1:0] b, exp_t e);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; reg1 = a; reg2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(S));
    chk(name, dut_out(), e);
    repeat (2) @(posedge clk);
  endtask

  op_e          sop [6] = '{OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_SUB};
  logic [W-1:0] sa  [6] = '{32'd100, 32'd7, 32'h8000_0000, 32'd0, 32'h1234_5678, 32'h8000_0000};
  logic [W-1:0] sb  [6] = '{32'd23,  32'd9, 32'h8000_0000, 32'd0, 32'h1111_1111, 32'd1};

  initial begin
    int   idx;
    int   base;
    logic acc;
    int   guard;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", dut_out(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("model_pin_sub", model(OP_SUB, 32'd30, 32'd10), mk(32'd20, 1, 0, 0, 0, 0));
    chk("model_pin_add_ovf", model(OP_ADD, 32'h7FFF_FFFF, 32'd1), mk(32'h8000_0000, 0, 0, 1, 0, 1));
    chk("model_pin_sub_ovf", model(OP_SUB, 32'h8000_0000, 32'd1), mk(32'h7FFF_FFFF, 1, 0, 1, 0, 0));

    run_one("sub_30_10",   OP_SUB, 32'd30, 32'd10, mk(32'd20, 1, 0, 0, 0, 0));
    run_one("sub_10_20",   OP_SUB, 32'd10, 32'd20, mk(32'hFFFF_FFF6, 0, 1, 0, 0, 1));
    run_one("add_wrap",    OP_ADD, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 1, 0, 0, 1, 0));
    run_one("add_ovf",     OP_ADD, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 0, 0, 1, 0, 1));
    run_one("sub_min_1",   OP_SUB, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 1, 0, 1, 0, 0));
    run_one("sub_equal",   OP_SUB, 32'd5, 32'd5, mk(32'd0, 1, 0, 0, 1, 0));
    run_one("add_segcarry", OP_ADD, 32'h00FF_FFFF, 32'd1, mk(32'h0100_0000, 0, 0, 0, 0, 0));

    // Back-to-back mixed stream with out_ready low in stream cycles 5..7.
    base = n_out;
    idx  = 0;
    acc  = 1'b0;
    for (int c = 0; c < 60 && (idx < 6 || exp_q.size() > 0); c++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (idx < 6);
      if (idx < 6) begin
        op = sop[idx]; reg1 = sa[idx]; reg2 = sb[idx];
      end
      #1;
      if (c < 10) chk($sformatf("stream_in_ready_c%0d", c), 64'(in_ready),
                      64'(!(c >= 5 && c <= 7 && S <= 5)));
      acc = in_valid && in_ready;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    chk("stream_count", 64'(n_out - base), 64'd6);
    chk("stream_drained", 64'(exp_q.size()), 64'd0);

    // Reset with three tokens in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; op = (i == 1) ? OP_SUB : OP_ADD;
      reg1 = 32'(1000 + i); reg2 = 32'(i + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("inflight_visible", 64'(out_valid), 64'd1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_outputs", dut_out(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 4) begin
      @(negedge clk); #1;
      chk("no_stale_after_reset", 64'(out_valid), 64'd0);
    end

    run_one("post_reset_add", OP_ADD, 32'd2, 32'd3, mk(32'd5, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors %0d miscompares %0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
